// File: rtl/device_io_controller.sv
// device_io_controller
//
// Memory-mapped I/O bridge between the processor data port and a byte-wide
// character device.  Two addresses are decoded: STATUS_ADDR (status word,
// write bit3=1 clears rx_overrun) and DATA_ADDR (write pushes a byte into the
// transmit FIFO, read returns the held receive byte).  All other addresses
// leave io_sel low and cause no side effects.
//
// Optional feature macro: IO_RX_EN (receive holding register).  When it is
// undefined, dev_rx_* are ignored, status bits 2/3 read 0 and DATA reads
// return 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_addr/wdata/we/re  processor data-port request
//   cpu_rdata             combinational read data (meaningful when io_sel=1)
//   io_sel                combinational address hit on STATUS_ADDR/DATA_ADDR
//   cpu_stall             combinational: data write while FIFO full
//   dev_tx_data/valid     FIFO head byte and non-empty flag
//   dev_tx_ready          device accepts the head byte this cycle
//   dev_rx_data/valid     incoming byte and its one-cycle strobe
//
// Handshake: a byte moves on a rising edge where dev_tx_valid and
// dev_tx_ready are both 1; dev_tx_data holds its value while valid=1 and
// ready=0, and valid never drops without a transfer except on reset.
module device_io_controller #(
  parameter logic [31:0] STATUS_ADDR = 32'hFFFF8000,
  parameter logic [31:0] DATA_ADDR   = 32'hFFFF8004,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  output logic        io_sel,
  output logic        cpu_stall,
  output logic [7:0]  dev_tx_data,
  output logic        dev_tx_valid,
  input  logic        dev_tx_ready,
  input  logic [7:0]  dev_rx_data,
  input  logic        dev_rx_valid
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic        w_stat_sel;
  logic        w_data_sel;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic [4:0]  w_count5;
  logic [31:0] w_status;
  logic [7:0]  w_rx_data;
  logic        w_rx_valid;
  logic        w_rx_overrun;

  assign w_stat_sel = (cpu_addr == STATUS_ADDR);
  assign w_data_sel = (cpu_addr == DATA_ADDR);
  assign io_sel     = w_stat_sel | w_data_sel;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);

  // Stall and push use only the registered full flag, so a pop in the same
  // cycle does not let the stalled write in until the following edge.
  assign cpu_stall = cpu_we & w_data_sel & w_full;
  assign w_push    = cpu_we & w_data_sel & ~w_full;
  assign w_pop     = ~w_empty & dev_tx_ready;

  assign dev_tx_valid = ~w_empty;
  assign dev_tx_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is cleared on reset so the head byte reads 8'h00 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= cpu_wdata[7:0];
    end
  end

`ifdef IO_RX_EN
  logic       r_rx_valid;
  logic       r_rx_overrun;
  logic [7:0] r_rx_data;
  logic       w_data_rd;
  logic       w_ovr_clr;
  logic       w_unused_rx;

  assign w_data_rd   = cpu_re & w_data_sel;
  assign w_ovr_clr   = cpu_we & w_stat_sel & cpu_wdata[3];
  assign w_unused_rx = ^cpu_wdata[31:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      // A new byte wins over a same-cycle overrun clear.
      if (w_ovr_clr) r_rx_overrun <= 1'b0;
      if (dev_rx_valid) begin
        r_rx_data  <= dev_rx_data;
        r_rx_valid <= 1'b1;
        // A byte consumed in the same cycle it is replaced is not lost.
        if (r_rx_valid && !w_data_rd) r_rx_overrun <= 1'b1;
      end else if (w_data_rd) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign w_rx_data    = r_rx_data;
  assign w_rx_valid   = r_rx_valid;
  assign w_rx_overrun = r_rx_overrun;
`else
  logic w_unused_rx;
  assign w_unused_rx  = ^{dev_rx_data, dev_rx_valid, cpu_re, cpu_wdata[31:8]};
  assign w_rx_data    = 8'h00;
  assign w_rx_valid   = 1'b0;
  assign w_rx_overrun = 1'b0;
`endif

  assign w_count5 = 5'(r_count);
  assign w_status = {23'b0, w_count5, w_rx_overrun, w_rx_valid, w_full, w_empty};

  always_comb begin
    cpu_rdata = 32'h0;
    if (w_stat_sel)      cpu_rdata = w_status;
    else if (w_data_sel) cpu_rdata = {24'b0, w_rx_data};
  end

endmodule

// File: tb/tb_device_io_controller.sv
`timescale 1ns/1ps
module tb_device_io_controller;

  localparam logic [31:0] STATUS = 32'hFFFF8000;
  localparam logic [31:0] DATA   = 32'hFFFF8004;
  localparam logic [31:0] OTHER  = 32'h00001000;
  localparam int          DEPTH  = 4;
`ifdef IO_RX_EN
  localparam bit RX = 1'b1;
`else
  localparam bit RX = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_rdata;
  logic        io_sel;
  logic        cpu_stall;
  logic [7:0]  dev_tx_data;
  logic        dev_tx_valid;
  logic        dev_tx_ready;
  logic [7:0]  dev_rx_data;
  logic        dev_rx_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  device_io_controller #(
    .STATUS_ADDR(STATUS),
    .DATA_ADDR  (DATA),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_we      (cpu_we),
    .cpu_re      (cpu_re),
    .cpu_rdata   (cpu_rdata),
    .io_sel      (io_sel),
    .cpu_stall   (cpu_stall),
    .dev_tx_data (dev_tx_data),
    .dev_tx_valid(dev_tx_valid),
    .dev_tx_ready(dev_tx_ready),
    .dev_rx_data (dev_rx_data),
    .dev_rx_valid(dev_rx_valid)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] exp_q[$];       // bytes queued for the device, head first
  logic       m_rxv;
  logic       m_ovr;
  logic [7:0] m_rxd;
  logic       m_stall;
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [4:0] c;
    c = 5'(exp_q.size());
    return {23'b0, c, m_ovr, m_rxv, (exp_q.size() == DEPTH), (exp_q.size() == 0)};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_rxv = 1'b0;
    m_ovr = 1'b0;
    m_rxd = 8'h00;
  endtask

  // ---------------- driver ----------------
  // One processor cycle: drive after the falling edge, check the
  // combinational outputs, then advance the model to the next rising edge.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                      input logic re, input logic rdy, input logic rxv, input logic [7:0] rxd);
    bit full, pop, push, data_rd, is_io;
    @(negedge clk);
    cpu_addr = a; cpu_wdata = wd; cpu_we = we; cpu_re = re;
    dev_tx_ready = rdy; dev_rx_valid = rxv; dev_rx_data = rxd;
    #1;
    is_io   = (a == STATUS) || (a == DATA);
    full    = (exp_q.size() == DEPTH);
    m_stall = we && (a == DATA) && full;
    chk("io_sel", {31'b0, io_sel}, {31'b0, is_io});
    chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, m_stall});
    chk("tx_valid", {31'b0, dev_tx_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("tx_data", {24'b0, dev_tx_data}, {24'b0, exp_q[0]});
    if (a == STATUS)    chk("rd_status", cpu_rdata, m_status());
    else if (a == DATA) chk("rd_data", cpu_rdata, {24'b0, m_rxd});
    pop  = (exp_q.size() != 0) && rdy;
    push = we && (a == DATA) && !full;
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back(wd[7:0]);
    if (RX) begin
      data_rd = re && (a == DATA);
      if (we && (a == STATUS) && wd[3]) m_ovr = 1'b0;
      if (rxv) begin
        if (m_rxv && !data_rd) m_ovr = 1'b1;
        m_rxv = 1'b1;
        m_rxd = rxd;
      end else if (data_rd) begin
        m_rxv = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic rdy);
    step(OTHER, 32'h0, 1'b0, 1'b0, rdy, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [31:0] a, input logic rdy);
    step(a, 32'h0, 1'b0, 1'b1, rdy, 1'b0, 8'h00);
  endtask

  // Processor write that holds while stalled, with a bounded wait.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic rdy);
    for (int k = 0; k < 20; k++) begin
      step(a, d, 1'b1, 1'b0, rdy, 1'b0, 8'h00);
      if (!m_stall) return;
    end
    n_assert++;
    n_fail++;
    $error("FAIL wr_timeout: observed stall after 20 cycles expected release");
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_clear();
    rst_n = 1'b0;
    cpu_addr = STATUS; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b1;
    dev_tx_ready = 1'b0; dev_rx_valid = 1'b0; dev_rx_data = 8'h00;
    #12;
    chk("reset_status", cpu_rdata, 32'h00000001);
    chk("reset_tx_valid", {31'b0, dev_tx_valid}, 32'h0);
    chk("reset_tx_data", {24'b0, dev_tx_data}, 32'h0);
    chk("reset_stall", {31'b0, cpu_stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(STATUS, 1'b0);

    // Single byte with the device ready.
    wr(DATA, 32'hDEAD_BE41, 1'b1);
    idle(1'b1);
    chk("tx41_data", {24'b0, dev_tx_data}, 32'h41);
    chk("tx41_valid", {31'b0, dev_tx_valid}, 32'h1);
    rd(STATUS, 1'b1);
    chk("tx41_status_after", cpu_rdata, 32'h00000001);

    // Fill to full with device stalled, then hold a fifth write.
    for (int i = 0; i < 4; i++) wr(DATA, 32'h10 + i, 1'b0);
    rd(STATUS, 1'b0);
    chk("full_status", cpu_rdata, 32'h00000042);
    for (int i = 0; i < 3; i++) begin
      step(DATA, 32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("stall_hold", {31'b0, cpu_stall}, 32'h1);
    end
    // Ready rises: this cycle still stalls, the push lands one edge later.
    step(DATA, 32'h14, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("stall_same_cycle_pop", {31'b0, cpu_stall}, 32'h1);
    wr(DATA, 32'h14, 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("drained_q", exp_q.size(), 32'h0);

    // Simultaneous push/pop across pointer wrap keeps count constant.
    wr(DATA, 32'h60, 1'b0);
    wr(DATA, 32'h61, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(DATA, 32'h62 + i, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      rd(STATUS, 1'b0);
      chk("pushpop_count", cpu_rdata, 32'h00000020);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Receive path.
    step(OTHER, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
    step(OTHER, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
    rd(STATUS, 1'b0);
    chk("rx_status", cpu_rdata, RX ? 32'h0000000D : 32'h00000001);
    rd(DATA, 1'b0);
    chk("rx_data", cpu_rdata, RX ? 32'h000000A5 : 32'h0);
    step(STATUS, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    rd(STATUS, 1'b0);
    chk("rx_ovr_clear", cpu_rdata, 32'h00000001);
    // Strobe while reading DATA: captured, valid stays, no overrun.
    step(OTHER, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
    step(DATA, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22);
    rd(STATUS, 1'b0);
    chk("rx_read_strobe", cpu_rdata, RX ? 32'h00000005 : 32'h00000001);
    rd(DATA, 1'b0);

    // Reset mid-transfer discards queued bytes.
    for (int i = 0; i < 3; i++) wr(DATA, 32'h70 + i, 1'b0);
    @(negedge clk);
    cpu_addr = STATUS; cpu_we = 1'b0; cpu_re = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_tx_valid", {31'b0, dev_tx_valid}, 32'h0);
    chk("midreset_status", cpu_rdata, 32'h00000001);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("post_reset_no_stale", {31'b0, dev_tx_valid}, 32'h0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      a = (sel < 5) ? DATA : (sel < 8) ? STATUS : OTHER;
      step(a, $urandom, ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), 8'($urandom));
    end
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("final_empty", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/device_io_controller.md
# device_io_controller

Memory-mapped I/O controller between the processor's data-memory port and an external byte-wide character device. It decodes two fixed I/O addresses (status and data), buffers processor writes to the data address in a small transmit FIFO, and drains that FIFO to the device over a valid/ready handshake. An optional receive path holds one incoming device byte for the processor to read. It stalls the processor when a transmit write hits a full FIFO. All other addresses pass through to data memory untouched.

## Interface
Parameters:
- STATUS_ADDR, 32'hFFFF8000, status register address
- DATA_ADDR, 32'hFFFF8004, data register address
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, 2..16

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cpu_addr  in  32  processor data address
- cpu_wdata  in  32  processor write data
- cpu_we  in  1  write strobe
- cpu_re  in  1  read strobe
- cpu_rdata  out  32  read data, combinational, valid when io_sel=1
- io_sel  out  1  combinational; 1 when cpu_addr equals STATUS_ADDR or DATA_ADDR; data memory must ignore the access
- cpu_stall  out  1  combinational; processor holds the current instruction
- dev_tx_data  out  8  FIFO head byte
- dev_tx_valid  out  1  FIFO non-empty
- dev_tx_ready  in  1  device accepts the byte
- dev_rx_data  in  8  incoming byte
- dev_rx_valid  in  1  one-cycle strobe qualifying dev_rx_data

## Operation
- Status word: bit0 tx_empty, bit1 tx_full, bit2 rx_valid, bit3 rx_overrun, bits[8:4] tx_count, all other bits 0.
- Read STATUS_ADDR: cpu_rdata = status word.
- Write STATUS_ADDR with cpu_wdata[3]=1: clears rx_overrun. All other bits are read-only.
- Write DATA_ADDR: pushes cpu_wdata[7:0] into the FIFO. Upper bits are ignored.
- Read DATA_ADDR: cpu_rdata = {24'b0, rx_data}. rx_valid clears at the next edge.
- cpu_stall = cpu_we & (cpu_addr==DATA_ADDR) & tx_full. While stalled, no push occurs. The push happens on the first edge where tx_full=0.
- cpu_stall is based on registered tx_full only. A pop in the same cycle does not release the stall; the push lands on the following edge.
- Transmit handshake:
  - dev_tx_valid = ~tx_empty; dev_tx_data = head entry.
  - A pop occurs on an edge with valid & ready.
  - dev_tx_data is stable while valid=1 and ready=0.
- Push and pop in the same cycle, FIFO non-full and non-empty: tx_count unchanged, both pointers advance.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- tx_count is kept separately, range 0..FIFO_DEPTH.
- Receive path:
  - A dev_rx_valid strobe loads rx_data and sets rx_valid.
  - A strobe arriving while rx_valid=1 overwrites rx_data and sets rx_overrun (sticky).
  - Strobe in the same cycle as a DATA read: new byte is captured, rx_valid stays 1, no overrun.
- cpu_we and cpu_re both asserted to the same I/O address: the write takes effect; the read returns pre-edge contents.
- No I/O side effects when io_sel=0.

## Timing
- Reset (asynchronous, on rst_n low):
  - FIFO empty, pointers 0, tx_count 0.
  - rx_data 8'h00; rx_valid, rx_overrun 0.
  - dev_tx_valid 0, dev_tx_data 8'h00, cpu_stall 0.
  - cpu_rdata is combinational; at reset it reads status 32'h00000001 when STATUS_ADDR is selected.
- Reset mid-transfer discards all FIFO contents; no byte is delivered after rst_n rises until a new push.
- Write to visible: a byte written at edge N shows dev_tx_valid=1 in cycle N+1 (FIFO was empty). It can pop at edge N+1.
- Sustained throughput is one byte per cycle when dev_tx_ready=1.
- Status reflects state registered at the previous edge.

## Configuration
- IO_RX_EN defined: receive path present as described.
- IO_RX_EN undefined:
  - dev_rx_data and dev_rx_valid remain as ports but are ignored.
  - Status bits 2 and 3 read 0.
  - DATA_ADDR reads return 32'h0.
  - No rx registers are synthesized.

## Test plan
- Reset then read STATUS_ADDR -> cpu_rdata=32'h00000001, dev_tx_valid=0, cpu_stall=0.
- Write 8'h41 to DATA_ADDR, dev_tx_ready=1 -> dev_tx_valid high one cycle with 8'h41, then status back to 32'h00000001.
- dev_tx_ready=0, write 5 bytes 8'h10..8'h14 (depth 4) -> status 32'h00000042 after four; fifth write holds cpu_stall=1. Raise ready -> stall releases, bytes emerge 8'h10..8'h14 in order.
- Fill-drain-fill across pointer wrap with simultaneous push/pop each cycle -> tx_count constant, no byte lost or duplicated.
- IO_RX_EN: strobe 8'h5A, strobe 8'hA5 -> status bits2,3 = 1; DATA read returns 32'h000000A5. Write STATUS 32'h8 -> overrun 0.
- Assert rst_n low with 3 bytes queued and ready=0 -> immediate dev_tx_valid=0; after release no stale bytes are emitted.
